// File: rtl/stream_mux_sel.sv
// N-way valid/ready packet multiplexer with fixed or round-robin channel select,
// packet locking and a registered output beat. Optional macro: STREAM_MUX_SEL_ERR_CNT_EN.
module stream_mux_sel #(
   parameter int WIDTH  = 8,
   parameter int NUM_CH = 10,
   parameter int SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    out_last,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        cur_ch,
   output logic                    sel_err,
   output logic [15:0]             err_cnt
);

   // state  | meaning
   // IDLE   | no channel owns the output; pick a candidate and grant it
   // LOCKED | cur_ch owns the output until its in_last beat is accepted
   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   state_t           state;
   logic [WIDTH-1:0] ch_data [NUM_CH];
   logic             sel_oor;
   logic [SEL_W-1:0] fx_cand;
   logic [SEL_W-1:0] rr_cand;
   logic             rr_found;
   logic [SEL_W:0]   rr_sum;
   logic [SEL_W-1:0] cand;
   logic             grant;
   logic             take;
   logic             accept;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_split
      assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
   end

   assign sel_oor = ({1'b0, sel} >= NUM_CH_X);
   assign fx_cand = sel_oor ? '0 : sel;

   // Upward search starting one past the last grant, wrapping at NUM_CH-1.
   always_comb begin
      rr_cand  = '0;
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         rr_sum = {1'b0, cur_ch} + (SEL_W+1)'(i);
         if (rr_sum >= NUM_CH_X) rr_sum = rr_sum - NUM_CH_X;
         if (!rr_found && in_valid[rr_sum[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_cand  = rr_sum[SEL_W-1:0];
         end
      end
   end

   assign cand   = mode ? rr_cand : fx_cand;
   assign grant  = (state == IDLE) && (mode ? rr_found : in_valid[cand]);
   assign take   = out_ready | ~out_valid;
   assign accept = (state == LOCKED) && in_valid[cur_ch] && take;

   always_comb begin
      in_ready = '0;
      if (state == LOCKED) in_ready[cur_ch] = take;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_ch    <= LAST_CH;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         sel_err   <= 1'b0;
      end else begin
         sel_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  cur_ch  <= cand;
                  state   <= LOCKED;
                  sel_err <= ~mode & sel_oor;
               end
            end
            LOCKED: begin
               if (accept && in_last[cur_ch]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Output register drains independently of the FSM state.
         if (accept) begin
            out_data  <= ch_data[cur_ch];
            out_last  <= in_last[cur_ch];
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_SEL_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            err_cnt <= '0;
      else if (sel_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
   end
`else
   assign err_cnt = 16'h0000;
`endif

endmodule
